vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Upstream stage of the bitmap ROM. Generates 640x480@60 Hz VGA timing from the system clock.
- Drives x_pixel, y_pixel and drawn_en straight into the ROM address stage.
- Provides hsync/vsync/blank delayed by SYNC_DELAY clocks so sync edges align with the ROM's registered pixel data (address register followed by data register, so 2 clks).

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_DELAY, 2, clk cycles of extra delay on hsync_d/vsync_d/blank_d; legal range 0..7

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- pix_tick  output  1  pixel-advance strobe
- x_pixel  output  10  visible column 0..639, else 0
- y_pixel  output  10  visible row 0..479, else 0
- drawn_en  output  1  high while the pixel is in the visible area
- hsync  output  1  horizontal sync, active low, undelayed
- vsync  output  1  vertical sync, active low, undelayed
- hsync_d  output  1  hsync delayed SYNC_DELAY clks
- vsync_d  output  1  vsync delayed SYNC_DELAY clks
- blank_d  output  1  ~drawn_en delayed SYNC_DELAY clks
- frame_start  output  1  one-clk pulse when position (0,0) is presented

Behaviour:
- Reset and clock: rst_n is asynchronous, active-low; clock is clk.
- Derived totals:
  - H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK (800).
  - V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK (525).
- Counters: h_cnt and v_cnt, 10-bit internal.
  - Both advance only on cycles where pix_tick = 1.
  - h_cnt counts 0..H_TOTAL-1, then wraps to 0 and v_cnt increments.
  - v_cnt wraps to 0 after V_TOTAL-1 when h_cnt also wraps.
- Decode stage: registered, updated every clk from the current counters, so latency is 1 clk from counter position to outputs.
  - drawn_en = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE).
  - x_pixel = h_cnt when h_cnt < H_VISIBLE, else 0.
  - y_pixel = v_cnt when v_cnt < V_VISIBLE, else 0.
  - hsync = 0 iff H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC (656..751).
  - vsync = 0 iff V_VISIBLE+V_FRONT <= v_cnt < V_VISIBLE+V_FRONT+V_SYNC (490..491).
  - frame_start = 1 for exactly one clk, when h_cnt=0, v_cnt=0 and pix_tick=1.
- Delay line: SYNC_DELAY-deep shift register on {hsync, vsync, ~drawn_en}, shifted every clk regardless of pix_tick.
  - SYNC_DELAY=0 makes the *_d outputs equal to the undelayed ones.
- Reset values:
  - h_cnt = v_cnt = 0, x_pixel = y_pixel = 0, drawn_en = 0, frame_start = 0.
  - hsync = vsync = 1.
  - All delay stages hold sync = 1 and blank = 1, so hsync_d = vsync_d = blank_d = 1.
  - pix_tick internal phase = 0.
- First clk edge after reset release latches position (0,0): drawn_en = 1, x = 0, y = 0.
- Reset mid-frame: everything returns to reset values immediately (asynchronous). No partial line is emitted after release; timing restarts at (0,0).
- Line/frame boundary: at h=799, v=524 the next position is (0,0). frame_start is asserted on that wrap. No one-cycle gap or double count.

Optional Feature:
- Macro: VGA_CLK_DIV2_EN.
- Defined:
  - clk is 50 MHz. pix_tick toggles 0,1,0,1… from reset (first tick on the 2nd clk after release).
  - Counters advance every second clk; decode registers still update every clk, so each position is held for 2 clks.
  - frame_start is asserted only on the tick cycle.
- Undefined:
  - clk is the 25 MHz pixel clock. pix_tick is tied to 1 and counters advance every clk.

Test Plan:
1. Release reset (no div) -> first clk: drawn_en=1, x=0, y=0, frame_start=1. Second clk: x=1. hsync_d/vsync_d/blank_d stay 1 for the first SYNC_DELAY clks.
2. Run one line -> drawn_en high exactly 640 consecutive clks, then low 160. hsync low for 96 clks beginning when the h position is 656. Line period 800 clks.
3. Run two frames -> frame_start pulses exactly every 420000 clks. vsync low for 1600 clks (lines 490-491). y_pixel=0 outside rows 0..479. drawn_en low on lines 480..524.
4. SYNC_DELAY=2 -> hsync_d(t) == hsync(t-2) and blank_d(t) == ~drawn_en(t-2) on every clk of a frame (scoreboard compare).
5. Assert rst_n low at position (300,200) for 3 clks, then release -> outputs take reset values asynchronously; first post-release clk presents (0,0) with frame_start=1.
6. With VGA_CLK_DIV2_EN -> each x value is held 2 clks. Line period 1600 clks; frame period 840000 clks. frame_start is 1 clk wide.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA 640x480@60 timing generator: pixel counters, registered decode and a sync/blank delay line.
// Optional macro VGA_CLK_DIV2_EN: run from a 2x system clock with a divide-by-two pixel strobe.
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int SYNC_DELAY = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pix_tick,
    output logic [9:0] x_pixel,
    output logic [9:0] y_pixel,
    output logic       drawn_en,
    output logic       hsync,
    output logic       vsync,
    output logic       hsync_d,
    output logic       vsync_d,
    output logic       blank_d,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       h_vis;
    logic       v_vis;

`ifdef VGA_CLK_DIV2_EN
    // Phase starts at 0 so the first pixel advance lands on the second clock after release.
    logic tick_phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_phase <= 1'b0;
        end else begin
            tick_phase <= ~tick_phase;
        end
    end

    assign pix_tick = tick_phase;
`else
    assign pix_tick = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_tick) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    always_comb begin
        h_vis = (h_cnt < H_VIS);
        v_vis = (v_cnt < V_VIS);
    end

    // Decode runs every clk, so in divided mode each position is presented for two clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_pixel     <= '0;
            y_pixel     <= '0;
            drawn_en    <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            x_pixel     <= h_vis ? h_cnt : '0;
            y_pixel     <= v_vis ? v_cnt : '0;
            drawn_en    <= h_vis && v_vis;
            hsync       <= !((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END));
            vsync       <= !((v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END));
            frame_start <= pix_tick && (h_cnt == '0) && (v_cnt == '0);
        end
    end

    generate
        if (SYNC_DELAY == 0) begin : g_no_delay
            assign hsync_d = hsync;
            assign vsync_d = vsync;
            assign blank_d = ~drawn_en;
        end else begin : g_delay
            // Newest sample sits in the low three bits; the oldest feeds the outputs.
            localparam int W = 3 * SYNC_DELAY;
            logic [W-1:0] chain;
            logic [W+2:0] chain_next;

            always_comb begin
                chain_next = {chain, hsync, vsync, ~drawn_en};
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    chain <= '1;
                end else begin
                    chain <= chain_next[W-1:0];
                end
            end

            assign {hsync_d, vsync_d, blank_d} = chain[W-1 -: 3];
        end
    endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: full 640x480 geometry plus a shrunken geometry for frame wraps.
`timescale 1ns/1ps
module tb_vga_timing_gen;

`ifdef VGA_CLK_DIV2_EN
    localparam bit DIV2 = 1'b1;
`else
    localparam bit DIV2 = 1'b0;
`endif

    typedef struct packed {
        logic       pix_tick;
        logic [9:0] x;
        logic [9:0] y;
        logic       drawn;
        logic       hs;
        logic       vs;
        logic       hs_d;
        logic       vs_d;
        logic       blank_d;
        logic       fs;
    } obs_t;

    typedef struct {
        int hv, hf, hs, hb, vv, vf, vs, vb, dly;
    } geom_t;

    geom_t g_full  = '{640, 16, 96, 48, 480, 10, 2, 33, 2};
    geom_t g_small = '{40, 4, 8, 6, 20, 2, 2, 3, 0};

    logic clk;
    logic rst_n;

    logic       f_tick, f_drawn, f_hs, f_vs, f_hsd, f_vsd, f_blank, f_fs;
    logic [9:0] f_x, f_y;
    logic       s_tick, s_drawn, s_hs, s_vs, s_hsd, s_vsd, s_blank, s_fs;
    logic [9:0] s_x, s_y;

    obs_t act_full;
    obs_t act_small;
    obs_t q_full[$];
    obs_t q_small[$];

    int k;
    int compared;
    int mismatched;

    vga_timing_gen dut_full (
        .clk(clk), .rst_n(rst_n), .pix_tick(f_tick), .x_pixel(f_x), .y_pixel(f_y),
        .drawn_en(f_drawn), .hsync(f_hs), .vsync(f_vs), .hsync_d(f_hsd), .vsync_d(f_vsd),
        .blank_d(f_blank), .frame_start(f_fs)
    );

    vga_timing_gen #(
        .H_VISIBLE(40), .H_FRONT(4), .H_SYNC(8), .H_BACK(6),
        .V_VISIBLE(20), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_DELAY(0)
    ) dut_small (
        .clk(clk), .rst_n(rst_n), .pix_tick(s_tick), .x_pixel(s_x), .y_pixel(s_y),
        .drawn_en(s_drawn), .hsync(s_hs), .vsync(s_vs), .hsync_d(s_hsd), .vsync_d(s_vsd),
        .blank_d(s_blank), .frame_start(s_fs)
    );

    assign act_full  = {f_tick, f_x, f_y, f_drawn, f_hs, f_vs, f_hsd, f_vsd, f_blank, f_fs};
    assign act_small = {s_tick, s_x, s_y, s_drawn, s_hs, s_vs, s_hsd, s_vsd, s_blank, s_fs};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Undelayed view after the k-th clock edge since reset release (k <= 0 means still in reset).
    function automatic obs_t base_view(geom_t g, int k_in);
        obs_t o;
        int   p, ht, vt, h, v;
        bit   tick;
        o          = '0;
        o.hs       = 1'b1;
        o.vs       = 1'b1;
        o.pix_tick = DIV2 ? (k_in % 2 == 1) : 1'b1;
        if (k_in <= 0) return o;
        ht      = g.hv + g.hf + g.hs + g.hb;
        vt      = g.vv + g.vf + g.vs + g.vb;
        p       = DIV2 ? (k_in - 1) / 2 : k_in - 1;
        tick    = DIV2 ? ((k_in - 1) % 2 == 1) : 1'b1;
        h       = p % ht;
        v       = (p / ht) % vt;
        o.drawn = (h < g.hv) && (v < g.vv);
        o.x     = (h < g.hv) ? 10'(h) : 10'd0;
        o.y     = (v < g.vv) ? 10'(v) : 10'd0;
        o.hs    = !((h >= g.hv + g.hf) && (h < g.hv + g.hf + g.hs));
        o.vs    = !((v >= g.vv + g.vf) && (v < g.vv + g.vf + g.vs));
        o.fs    = tick && (h == 0) && (v == 0);
        return o;
    endfunction

    function automatic obs_t expect_at(geom_t g, int k_in);
        obs_t o;
        obs_t d;
        o         = base_view(g, k_in);
        d         = base_view(g, k_in - g.dly);
        o.hs_d    = d.hs;
        o.vs_d    = d.vs;
        o.blank_d = !d.drawn;
        return o;
    endfunction

    // One clock per iteration: update the edge count, change reset mid-cycle, then queue expectations.
    task automatic apply_stimulus(input int cycles, input bit rst_level);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            if (rst_n) k = k + 1;
            else       k = 0;
            #2;
            rst_n = rst_level;
            if (!rst_n) k = 0;
            #1;
            q_full.push_back(expect_at(g_full, k));
            q_small.push_back(expect_at(g_small, k));
        end
    endtask

    task automatic check_output(input string name, input obs_t act, input obs_t exp);
        compared = compared + 1;
        if (act !== exp) begin
            mismatched = mismatched + 1;
            $display("[TB] FAIL %s t=%0t got x=%0d y=%0d flags=%h want x=%0d y=%0d flags=%h",
                     name, $time, act.x, act.y, {act.pix_tick, act.drawn, act.hs, act.vs,
                     act.hs_d, act.vs_d, act.blank_d, act.fs}, exp.x, exp.y,
                     {exp.pix_tick, exp.drawn, exp.hs, exp.vs, exp.hs_d, exp.vs_d,
                     exp.blank_d, exp.fs});
        end
    endtask

    always @(negedge clk) begin
        if (q_full.size() > 0) check_output("full", act_full, q_full.pop_front());
        if (q_small.size() > 0) check_output("small", act_small, q_small.pop_front());
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        k          = 0;
        rst_n      = 1'b0;
        apply_stimulus(3, 1'b0);
        apply_stimulus(1, 1'b1);
        apply_stimulus(7000, 1'b1);
        for (int r = 0; r < 6; r++) begin
            apply_stimulus(int'($urandom_range(200, 3000)), 1'b1);
            apply_stimulus(1, 1'b0);
            apply_stimulus(int'($urandom_range(1, 4)), 1'b0);
            apply_stimulus(1, 1'b1);
        end
        apply_stimulus(2000, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        if (q_full.size() != 0 || q_small.size() != 0) begin
            compared   = compared + 1;
            mismatched = mismatched + 1;
            $display("[TB] FAIL drain got %0d/%0d pending want 0/0", q_full.size(), q_small.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
